// File: rtl/fir_pkg.sv
// Shared types and constants for the 2-D 3-tap FIR frame sequencer.
package fir_pkg;

    localparam int FIR_COEFF_W = 14;
    localparam int FIR_LINE_W  = 12;
    localparam int MIN_H_SIZE  = 3;
    localparam int MIN_V_SIZE  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } fir_state_e;

    typedef struct packed {
        logic [3*FIR_COEFF_W-1:0] coeff_v;
        logic [3*FIR_COEFF_W-1:0] coeff_h;
        logic [FIR_LINE_W-1:0]    h_size;
        logic [FIR_LINE_W-1:0]    v_size;
    } cfg_bank_t;

    // Frames smaller than the 3x3 kernel footprint cannot be filtered.
    function automatic logic cfg_ok(input cfg_bank_t b);
        return (b.h_size >= FIR_LINE_W'(MIN_H_SIZE)) && (b.v_size >= FIR_LINE_W'(MIN_V_SIZE));
    endfunction

endpackage

// File: rtl/fir_frame_ctrl_if.sv
// Pixel stream in and filter drive out of the FIR frame sequencer.
// slave = sequencer side, master = stream source / filter observer side.
interface fir_frame_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int LINE_CNT    = 12
);
    logic                     s_valid_i;
    logic                     s_ready_o;
    logic [DATA_WIDTH-1:0]    s_data_i;
    logic                     fir_ce_o;
    logic                     fir_valid_o;
    logic [DATA_WIDTH-1:0]    fir_data_o;
    logic [3*COEFF_WIDTH-1:0] fir_coeff_v_o;
    logic [3*COEFF_WIDTH-1:0] fir_coeff_h_o;
    logic [LINE_CNT-1:0]      fir_h_size_o;
    logic [LINE_CNT-1:0]      fir_v_size_o;

    modport slave (
        input  s_valid_i, s_data_i,
        output s_ready_o, fir_ce_o, fir_valid_o, fir_data_o,
               fir_coeff_v_o, fir_coeff_h_o, fir_h_size_o, fir_v_size_o
    );

    modport master (
        output s_valid_i, s_data_i,
        input  s_ready_o, fir_ce_o, fir_valid_o, fir_data_o,
               fir_coeff_v_o, fir_coeff_h_o, fir_h_size_o, fir_v_size_o
    );
endinterface

// File: rtl/fir_cfg_shadow.sv
// Shadow/active configuration register pair; shadow takes host writes at any time,
// active copies shadow only on the load strobe so the filter sees a stable bank per frame.
module fir_cfg_shadow
    import fir_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr,
    input  cfg_bank_t wr_bank,
    input  logic      load,
    output cfg_bank_t shadow,
    output cfg_bank_t active
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr)
                shadow <= wr_bank;
            if (load)
                active <= shadow;
        end
    end

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for the 2-D 3-tap FIR: pixel in -> fir beat out 1 cycle, start -> first ready 2 cycles.
// Upstream is held off (s_ready_o=0) outside RUN; FLUSH_LINES*h_size zero beats drain the line buffers.
// FIR_FRAME_STALL_CNT_EN adds a saturating count of RUN cycles with no upstream pixel.
module fir_frame_ctrl
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int LINE_CNT    = 12,
    parameter int FLUSH_LINES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr_i,
    input  logic [3*COEFF_WIDTH-1:0] cfg_coeff_v_i,
    input  logic [3*COEFF_WIDTH-1:0] cfg_coeff_h_i,
    input  logic [LINE_CNT-1:0]      cfg_h_size_i,
    input  logic [LINE_CNT-1:0]      cfg_v_size_i,
    input  logic                     start_i,
    fir_frame_ctrl_if.slave          bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [15:0]              stall_cnt_o
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_FLUSH = ST_FLUSH;
    localparam logic [2:0] S_DONE  = ST_DONE;

    if (COEFF_WIDTH != FIR_COEFF_W || LINE_CNT != FIR_LINE_W) begin : g_width_chk
        $error("fir_frame_ctrl: COEFF_WIDTH/LINE_CNT must match fir_pkg bank widths");
    end
    if (FLUSH_LINES < 1 || FLUSH_LINES > 3) begin : g_flush_chk
        $error("fir_frame_ctrl: FLUSH_LINES must be 1..3");
    end

    cfg_bank_t wr_bank;
    cfg_bank_t shadow;
    cfg_bank_t active;
    cfg_bank_t eff_cfg;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [LINE_CNT-1:0]   x_cnt;
    logic [LINE_CNT-1:0]   y_cnt;
    logic [15:0]           flush_cnt;
    logic [15:0]           flush_total;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic load;
    logic in_run;
    logic in_flush;
    logic hs;
    logic x_last;
    logic y_last;
    logic flush_last;
    logic start_ok;
    logic start_rej;

    assign wr_bank = '{coeff_v: cfg_coeff_v_i,
                       coeff_h: cfg_coeff_h_i,
                       h_size:  cfg_h_size_i,
                       v_size:  cfg_v_size_i};

    fir_cfg_shadow u_cfg_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (cfg_wr_i),
        .wr_bank (wr_bank),
        .load    (load),
        .shadow  (shadow),
        .active  (active)
    );

    // A write landing in the same cycle as start is what LOAD will copy, so validate that.
    assign eff_cfg = cfg_wr_i ? wr_bank : shadow;

    assign load     = (state == S_LOAD);
    assign in_run   = (state == S_RUN);
    assign in_flush = (state == S_FLUSH);

    assign hs          = bus.s_valid_i & bus.s_ready_o;
    assign x_last      = (x_cnt == active.h_size - LINE_CNT'(1));
    assign y_last      = (y_cnt == active.v_size - LINE_CNT'(1));
    assign flush_total = 16'(FLUSH_LINES) * 16'(active.h_size);
    assign flush_last  = (flush_cnt == flush_total - 16'd1);

    assign start_ok  = (state == S_IDLE) & start_i &  cfg_ok(eff_cfg);
    assign start_rej = (state == S_IDLE) & start_i & ~cfg_ok(eff_cfg);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (hs && x_last && y_last) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            flush_cnt <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= start_rej;
            vld_q <= hs | in_flush;

            if (hs)
                data_q <= bus.s_data_i;
            else if (in_flush)
                data_q <= '0;

            if (load) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (hs) begin
                if (x_last) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + LINE_CNT'(1);
                end else begin
                    x_cnt <= x_cnt + LINE_CNT'(1);
                end
            end

            if (in_flush)
                flush_cnt <= flush_cnt + 16'd1;
            else
                flush_cnt <= '0;
        end
    end

    assign bus.s_ready_o     = in_run;
    assign bus.fir_ce_o      = in_run | in_flush;
    assign bus.fir_valid_o   = vld_q;
    assign bus.fir_data_o    = data_q;
    assign bus.fir_coeff_v_o = active.coeff_v;
    assign bus.fir_coeff_h_o = active.coeff_h;
    assign bus.fir_h_size_o  = active.h_size;
    assign bus.fir_v_size_o  = active.v_size;

    assign busy_o = load | in_run | in_flush;
    assign done_o = (state == S_DONE);
    assign err_o  = err_q;

`ifdef FIR_FRAME_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Held after DONE so the host can read it; only the next LOAD clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (load)
            stall_cnt <= '0;
        else if (in_run && !bus.s_valid_i && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Directed + randomized bench for fir_frame_ctrl against a frame-level reference model.
module tb_fir_frame_ctrl;
    import fir_pkg::*;

    localparam int DW = 8;
    localparam int CW = 14;
    localparam int LW = 12;
    localparam int FL = 1;

    logic          clk;
    logic          rst_n;
    logic          cfg_wr;
    logic [3*CW-1:0] cfg_coeff_v;
    logic [3*CW-1:0] cfg_coeff_h;
    logic [LW-1:0] cfg_h_size;
    logic [LW-1:0] cfg_v_size;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   stall_cnt;

    fir_frame_ctrl_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .LINE_CNT(LW)) bus ();

    fir_frame_ctrl #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .LINE_CNT(LW), .FLUSH_LINES(FL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wr_i      (cfg_wr),
        .cfg_coeff_v_i (cfg_coeff_v),
        .cfg_coeff_h_i (cfg_coeff_h),
        .cfg_h_size_i  (cfg_h_size),
        .cfg_v_size_i  (cfg_v_size),
        .start_i       (start),
        .bus           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .stall_cnt_o   (stall_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt  = 0;
    logic [DW-1:0] got_q[$];
    int            tcy_q[$];
    logic [DW-1:0] exp_q[$];
    logic [3*CW-1:0] cur_cv;
    logic [3*CW-1:0] cur_ch;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fir_valid_o) begin
            got_q.push_back(bus.fir_data_o);
            tcy_q.push_back(cyc - base);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - base;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // vld_mode: 0 always valid, 1 valid every other cycle, 2 random.
    // wr_mode: 0 keep shadow, 1 write the cycle before start, 2 write with start.
    task automatic run_frame(input int h, input int v, input int wr_mode, input int vld_mode,
                             input int mid_h, input bit timing);
        int n, sent, stalls, k, g, gb, db, eb;
        logic vb;
        logic [DW-1:0] pix;
        n = h * v; sent = 0; stalls = 0; k = 0; g = 0;
        exp_q.delete();
        if (wr_mode != 0) begin
            cur_cv = 42'({$urandom(), $urandom()});
            cur_ch = 42'({$urandom(), $urandom()});
            cfg_coeff_v = cur_cv; cfg_coeff_h = cur_ch;
            cfg_h_size = LW'(h); cfg_v_size = LW'(v);
            cfg_wr = 1'b1;
            if (wr_mode == 1) begin
                tick();
                cfg_wr = 1'b0;
            end
        end
        gb = got_q.size(); db = done_cnt; eb = err_cnt;
        start = 1'b1;
        base = cyc;
        tick();
        start = 1'b0; cfg_wr = 1'b0;
        check("ready_load", 64'(bus.s_ready_o), 64'd0);
        check("busy_load", 64'(busy), 64'd1);
        tick();
        check("coeff_v", 64'(bus.fir_coeff_v_o), 64'(cur_cv));
        check("coeff_h", 64'(bus.fir_coeff_h_o), 64'(cur_ch));
        check("v_size", 64'(bus.fir_v_size_o), 64'(v));
        while (sent < n && k < 5000) begin
            case (vld_mode)
                0:       vb = 1'b1;
                1:       vb = (k % 2 == 0);
                default: vb = ($urandom_range(99) < 70);
            endcase
            pix = DW'($urandom_range(255, 1));
            bus.s_valid_i = vb;
            bus.s_data_i  = pix;
            start  = (sent == 3);
            cfg_wr = (mid_h != 0 && sent == 2);
            if (cfg_wr) cfg_h_size = LW'(mid_h);
            check("ready_run", 64'(bus.s_ready_o), 64'd1);
            check("ce_run", 64'(bus.fir_ce_o), 64'd1);
            check("hsize_run", 64'(bus.fir_h_size_o), 64'(h));
            if (vb) begin
                exp_q.push_back(pix);
                sent++;
            end else begin
                stalls++;
            end
            k++;
            tick();
        end
        bus.s_valid_i = 1'b0; start = 1'b0; cfg_wr = 1'b0;
        for (int i = 0; i < FL * h; i++) exp_q.push_back('0);
        check("ready_flush", 64'(bus.s_ready_o), 64'd0);
        check("busy_flush", 64'(busy), 64'd1);
        while (done_cnt == db && g < 500) begin
            tick();
            g++;
        end
        tick(); tick();
        check("done_once", 64'(done_cnt - db), 64'd1);
        check("no_err", 64'(err_cnt - eb), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("ce_after", 64'(bus.fir_ce_o), 64'd0);
        check("ready_after", 64'(bus.s_ready_o), 64'd0);
        check("hsize_after", 64'(bus.fir_h_size_o), 64'(h));
        check("beat_count", 64'(got_q.size() - gb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++)
            check("beat_data", 64'(got_q[gb + i]), 64'(exp_q[i]));
        if (timing) begin
            for (int i = 0; i < exp_q.size() && gb + i < tcy_q.size(); i++)
                check("beat_cycle", 64'(tcy_q[gb + i]), 64'(3 + i));
            check("done_cycle", 64'(done_cyc), 64'(2 + n + FL * h));
        end
`ifdef FIR_FRAME_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`else
        check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic bad_start(input int h, input int v, input bit wr_first);
        int eb;
        if (wr_first) begin
            cfg_h_size = LW'(h); cfg_v_size = LW'(v); cfg_wr = 1'b1;
            tick();
            cfg_wr = 1'b0;
        end
        eb = err_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bad_busy", 64'(busy), 64'd0);
            check("bad_ready", 64'(bus.s_ready_o), 64'd0);
            tick();
        end
        check("bad_err_once", 64'(err_cnt - eb), 64'd1);
    endtask

    initial begin
        int db;
        rst_n = 1'b0; cfg_wr = 1'b0; start = 1'b0;
        cfg_coeff_v = '0; cfg_coeff_h = '0; cfg_h_size = '0; cfg_v_size = '0;
        bus.s_valid_i = 1'b0; bus.s_data_i = '0;
        cur_cv = '0; cur_ch = '0;
        repeat (3) tick();
        check("rst_ready", 64'(bus.s_ready_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_valid", 64'(bus.fir_valid_o), 64'd0);
        check("rst_ce", 64'(bus.fir_ce_o), 64'd0);
        check("rst_hsize", 64'(bus.fir_h_size_o), 64'd0);
        check("rst_coeff", 64'(bus.fir_coeff_h_o), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Empty shadow after reset, then the two size boundaries just below legal.
        bad_start(0, 0, 1'b0);
        bad_start(2, 5, 1'b1);
        bad_start(3, 2, 1'b1);

        run_frame(4, 3, 1, 0, 0, 1'b1);
        run_frame(4, 3, 0, 1, 0, 1'b0);
        run_frame(3, 3, 1, 2, 0, 1'b0);

        // Shadow left illegal so only the same-cycle write can make this frame start.
        cfg_h_size = LW'(2); cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        run_frame(6, 3, 2, 0, 0, 1'b1);

        run_frame(4, 3, 1, 2, 8, 1'b0);
        run_frame(8, 3, 0, 0, 0, 1'b1);

        // Abort mid-frame with reset.
        cfg_h_size = LW'(4); cfg_v_size = LW'(3); cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        db = done_cnt;
        start = 1'b1; tick(); start = 1'b0; tick();
        bus.s_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data_i = DW'(i + 1);
            tick();
        end
        bus.s_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(bus.s_ready_o), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ce", 64'(bus.fir_ce_o), 64'd0);
        check("abort_valid", 64'(bus.fir_valid_o), 64'd0);
        check("abort_data", 64'(bus.fir_data_o), 64'd0);
        check("abort_hsize", 64'(bus.fir_h_size_o), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("abort_no_done", 64'(done_cnt - db), 64'd0);
        cur_cv = '0; cur_ch = '0;
        run_frame(5, 4, 1, 2, 0, 1'b0);

        for (int r = 0; r < 4; r++)
            run_frame(int'($urandom_range(10, 3)), int'($urandom_range(6, 3)), 1, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
